// File: rtl/vram_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_bus_pkg
//  Description : Shared constants for the CPU-side video-RAM bus master:
//                video window geometry, default window base, state codes
//                and the window hit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_bus_pkg;

    // Width of the word offset inside the video window.
    localparam int c_win_w = 15;

    // Number of physically implemented words in the window.
    localparam int c_vram_words = 21504;

    // Default word address of the video window (only [21:15] matter).
    localparam logic [21:0] c_vram_base = 22'o17000000;

    // FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_wr    = 3'd1;
    localparam state_t c_st_wwait = 3'd2;
    localparam state_t c_st_rd    = 3'd3;
    localparam state_t c_st_ack   = 3'd4;

    // True when a CPU word address falls in the window based at 'base'.
    function automatic logic win_hit(input logic [21:0] addr,
                                     input logic [21:0] base);
        return addr[21:c_win_w] == base[21:c_win_w];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vram_bus_timer
//  Description : Clearable up-counter with a terminal-count flag used to
//                bound the wait for the RAM controller's ready/done.
//  Ports       : cpu_clk  - clock
//                reset    - synchronous, active-high
//                clear    - force count to 0 (wins over enable)
//                enable   - count up by one this cycle
//                terminal - count == TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_bus_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic cpu_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_tc = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    // Holding at terminal keeps the counter from wrapping if the owner
    // lingers for a cycle after the flag is raised.
    always_ff @(posedge cpu_clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_tc)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign terminal = (r_count == c_tc);

endmodule
`default_nettype wire

// File: rtl/vram_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : vram_bus_master
//  Description : CPU-side initiator for the video-RAM port of the RAM
//                controller. Decodes the video window, issues single-word
//                read/write cycles to the controller, and returns data plus
//                a one-cycle ack (with error flag) to the CPU.
//  Ports       : cpu_clk, reset          - clock, sync active-high reset
//                bus_req/write/addr/data_in - CPU request (held until ack)
//                bus_data_out            - registered read data
//                bus_ack, bus_err        - completion pulse and error flag
//                bus_busy                - transaction in progress
//                err_count               - saturating error-ack count
//                vram_cpu_*              - RAM controller video port
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_bus_master
    import vram_bus_pkg::*;
#(
    parameter logic [21:0] VRAM_BASE      = c_vram_base,
    parameter int          VRAM_WORDS     = c_vram_words,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                 cpu_clk,
    input  logic                 reset,
    // CPU bus
    input  logic                 bus_req,
    input  logic                 bus_write,
    input  logic [21:0]          bus_addr,
    input  logic [31:0]          bus_data_in,
    output logic [31:0]          bus_data_out,
    output logic                 bus_ack,
    output logic                 bus_err,
    output logic                 bus_busy,
    output logic [7:0]           err_count,
    // RAM controller video port
    output logic [c_win_w-1:0]   vram_cpu_addr,
    output logic [31:0]          vram_cpu_data_in,
    input  logic [31:0]          vram_cpu_data_out,
    output logic                 vram_cpu_req,
    output logic                 vram_cpu_write,
    input  logic                 vram_cpu_ready,
    input  logic                 vram_cpu_done
);

    localparam int c_lim_w = c_win_w + 1;
    localparam logic [c_lim_w-1:0] c_words_lim = c_lim_w'(VRAM_WORDS);

    state_t              r_state;
    logic [31:0]         r_data_out;
    logic                r_bus_err;
    logic [7:0]          r_err_count;
    logic [c_win_w-1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic                r_req;
    logic                r_write;

    logic [c_win_w-1:0]  w_offset;
    logic                w_hit;
    logic                w_in_range;
    logic                w_timer_clr;
    logic                w_timer_en;
    logic                w_timeout;

    assign w_offset   = bus_addr[c_win_w-1:0];
    assign w_hit      = win_hit(bus_addr, VRAM_BASE);
    assign w_in_range = {1'b0, w_offset} < c_words_lim;

    // The timer is parked at zero outside an access and only runs while
    // actually waiting on the controller; WR holds it at zero so the
    // timeout window is measured from WWAIT entry.
    assign w_timer_clr = (r_state == c_st_idle) || (r_state == c_st_ack);
    assign w_timer_en  = (r_state == c_st_wwait) || (r_state == c_st_rd);

    vram_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .clear    (w_timer_clr),
        .enable   (w_timer_en),
        .terminal (w_timeout)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_data_out  <= '0;
            r_bus_err   <= 1'b0;
            r_err_count <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req       <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // Non-window requests are left for other slaves.
                    if (bus_req && w_hit) begin
                        if (!w_in_range) begin
                            r_bus_err <= 1'b1;
                            r_state   <= c_st_ack;
                        end else if (bus_write) begin
                            r_addr  <= w_offset;
                            r_wdata <= bus_data_in;
                            r_write <= 1'b1;
                            r_state <= c_st_wr;
                        end else if (!vram_cpu_ready) begin
                            // Ready lags req, so a ready still high from the
                            // previous read would be mistaken for this one.
                            r_addr  <= w_offset;
                            r_req   <= 1'b1;
                            r_state <= c_st_rd;
                        end
                    end
                end

                c_st_wr: begin
                    r_write <= 1'b0;
                    r_state <= vram_cpu_done ? c_st_ack : c_st_wwait;
                end

                c_st_wwait: begin
                    // Done takes priority over a coincident timeout.
                    if (vram_cpu_done) begin
                        r_state <= c_st_ack;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= c_st_ack;
                    end
                end

                c_st_rd: begin
                    if (vram_cpu_ready) begin
                        r_data_out <= vram_cpu_data_out;
                        r_req      <= 1'b0;
                        r_state    <= c_st_ack;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= c_st_ack;
                    end
                end

                c_st_ack: begin
                    if (r_bus_err && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_bus_err <= 1'b0;
                    r_state   <= c_st_idle;
                end

                default: begin
                    r_req     <= 1'b0;
                    r_write   <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign bus_data_out     = r_data_out;
    assign bus_ack          = (r_state == c_st_ack);
    assign bus_err          = r_bus_err;
    assign bus_busy         = (r_state != c_st_idle);
    assign err_count        = r_err_count;
    assign vram_cpu_addr    = r_addr;
    assign vram_cpu_data_in = r_wdata;
    assign vram_cpu_req     = r_req;
    assign vram_cpu_write   = r_write;

endmodule
`default_nettype wire

// File: tb/tb_vram_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_bus_master
//  Description : Directed self-checking bench for vram_bus_master with a
//                small RAM-controller model: ready rises three cycles after
//                the controller first samples req (and falls the same way),
//                done pulses two cycles after it samples the write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_bus_master;

    localparam logic [21:0] c_base = 22'o17000000;

    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_write = 1'b0;
    logic [21:0] bus_addr = '0;
    logic [31:0] bus_data_in = '0;
    logic [31:0] bus_data_out;
    logic        bus_ack;
    logic        bus_err;
    logic        bus_busy;
    logic [7:0]  err_count;
    logic [14:0] vram_cpu_addr;
    logic [31:0] vram_cpu_data_in;
    logic [31:0] vram_cpu_data_out;
    logic        vram_cpu_req;
    logic        vram_cpu_write;
    logic        vram_cpu_ready;
    logic        vram_cpu_done;

    // controller model state
    logic [3:0]  r_req_sh;
    logic [2:0]  r_wr_sh;
    logic        r_mem_vld;
    logic [14:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic        done_en   = 1'b1;
    logic        late_done = 1'b0;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    vram_bus_master dut (
        .cpu_clk           (cpu_clk),
        .reset             (reset),
        .bus_req           (bus_req),
        .bus_write         (bus_write),
        .bus_addr          (bus_addr),
        .bus_data_in       (bus_data_in),
        .bus_data_out      (bus_data_out),
        .bus_ack           (bus_ack),
        .bus_err           (bus_err),
        .bus_busy          (bus_busy),
        .err_count         (err_count),
        .vram_cpu_addr     (vram_cpu_addr),
        .vram_cpu_data_in  (vram_cpu_data_in),
        .vram_cpu_data_out (vram_cpu_data_out),
        .vram_cpu_req      (vram_cpu_req),
        .vram_cpu_write    (vram_cpu_write),
        .vram_cpu_ready    (vram_cpu_ready),
        .vram_cpu_done     (vram_cpu_done)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    always @(posedge cpu_clk) begin
        if (reset) begin
            r_req_sh  <= '0;
            r_wr_sh   <= '0;
            r_mem_vld <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_req_sh <= {r_req_sh[2:0], vram_cpu_req};
            r_wr_sh  <= {r_wr_sh[1:0], vram_cpu_write};
            if (vram_cpu_write) begin
                r_mem_vld  <= 1'b1;
                r_mem_addr <= vram_cpu_addr;
                r_mem_data <= vram_cpu_data_in;
            end
        end
    end

    assign vram_cpu_ready    = r_req_sh[3];
    assign vram_cpu_done     = (r_wr_sh[2] & done_en) | late_done;
    // Unwritten words read back as C0DE_<offset>.
    assign vram_cpu_data_out = !vram_cpu_ready ? 32'h0 :
                               (r_mem_vld && (vram_cpu_addr == r_mem_addr)) ? r_mem_data :
                               {16'hC0DE, 1'b0, vram_cpu_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    task automatic start(input logic wr, input logic [21:0] addr, input logic [31:0] data);
        bus_req     = 1'b1;
        bus_write   = wr;
        bus_addr    = addr;
        bus_data_in = data;
    endtask

    // Runs negedge by negedge until bus_ack (bounded). acc is the negedge
    // right after the accept edge (first req or strobe seen).
    task automatic run_to_ack(input int budget, output logic seen, output int acc,
                              output int ack, output int req_cnt, output int wr_cnt,
                              output logic [14:0] st_addr, output logic [31:0] st_data);
        seen = 1'b0; acc = -1; ack = -1; req_cnt = 0; wr_cnt = 0;
        st_addr = '0; st_data = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge cpu_clk);
            if (vram_cpu_req) begin
                req_cnt++;
                if (acc < 0) acc = cyc;
            end
            if (vram_cpu_write) begin
                wr_cnt++;
                if (acc < 0) acc = cyc;
                st_addr = vram_cpu_addr;
                st_data = vram_cpu_data_in;
            end
            if (bus_ack) begin
                seen = 1'b1;
                ack  = cyc;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        seen;
        int          acc, ack, acc2, ack1, req_cnt, wr_cnt, act;
        logic [14:0] st_addr;
        logic [31:0] st_data;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_ack",   32'(bus_ack), 0);
        check("rst_err",   32'(bus_err), 0);
        check("rst_busy",  32'(bus_busy), 0);
        check("rst_errcnt", 32'(err_count), 0);
        check("rst_vreq",  32'({vram_cpu_req, vram_cpu_write}), 0);
        check("rst_vaddr", 32'(vram_cpu_addr), 0);
        check("rst_vdata", vram_cpu_data_in, 0);
        check("rst_rdata", bus_data_out, 0);
        reset = 1'b0;
        idle(2);

        // ---------------- write offset 5 ----------------
        start(1'b1, c_base | 22'd5, 32'hDEADBEEF);
        run_to_ack(40, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("wr_ack_seen", 32'(seen), 1);
        check("wr_strobe_cnt", 32'(wr_cnt), 1);
        check("wr_addr", 32'(st_addr), 5);
        check("wr_data", st_data, 32'hDEADBEEF);
        check("wr_latency", 32'(ack - acc), 4);
        check("wr_err", 32'(bus_err), 0);
        idle(8);

        // ---------------- read offset 5 ----------------
        start(1'b0, c_base | 22'd5, 32'h0);
        run_to_ack(40, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("rd_ack_seen", 32'(seen), 1);
        check("rd_data", bus_data_out, 32'hDEADBEEF);
        check("rd_latency", 32'(ack - acc), 5);
        check("rd_req_cycles", 32'(req_cnt), 5);
        check("rd_err", 32'(bus_err), 0);
        idle(8);

        // ---------------- back-to-back reads 1 then 2 ----------------
        start(1'b0, c_base | 22'd1, 32'h0);
        run_to_ack(40, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        check("b2b1_ack_seen", 32'(seen), 1);
        check("b2b1_data", bus_data_out, 32'hC0DE0001);
        ack1 = ack;
        bus_addr = c_base | 22'd2;   // req stays high: a new request
        run_to_ack(60, seen, acc2, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("b2b2_ack_seen", 32'(seen), 1);
        check("b2b2_data", bus_data_out, 32'hC0DE0002);
        // ready from read 1 stays up until 4 edges after its ack edge
        check("b2b2_holdoff", 32'(acc2 - ack1), 5);
        check("b2b2_latency", 32'(ack - acc2), 5);
        idle(8);

        // ---------------- out-of-range read ----------------
        start(1'b0, c_base | 22'd21504, 32'h0);
        run_to_ack(20, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("oor_ack_seen", 32'(seen), 1);
        check("oor_err", 32'(bus_err), 1);
        check("oor_no_ctrl", 32'(req_cnt + wr_cnt), 0);
        @(negedge cpu_clk);
        check("oor_errcnt", 32'(err_count), 1);
        check("oor_err_clr", 32'(bus_err), 0);
        check("oor_data_kept", bus_data_out, 32'hC0DE0002);

        // ---------------- outside window ----------------
        start(1'b0, 22'd0, 32'h0);
        act = 0;
        repeat (10) begin
            @(negedge cpu_clk);
            if (bus_ack || bus_busy || vram_cpu_req || vram_cpu_write) act++;
        end
        bus_req = 1'b0;
        check("miss_activity", 32'(act), 0);
        idle(2);

        // ---------------- write timeout ----------------
        done_en = 1'b0;
        start(1'b1, c_base | 22'd7, 32'h12345678);
        run_to_ack(120, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("to_ack_seen", 32'(seen), 1);
        check("to_err", 32'(bus_err), 1);
        // strobe edge + 1 = WWAIT entry, then 64 cycles
        check("to_latency", 32'(ack - acc), 65);
        @(negedge cpu_clk);
        check("to_errcnt", 32'(err_count), 2);
        idle(2);
        late_done = 1'b1;
        @(negedge cpu_clk);
        late_done = 1'b0;
        act = 0;
        repeat (6) begin
            @(negedge cpu_clk);
            if (bus_ack || bus_busy) act++;
        end
        check("late_done_ignored", 32'(act), 0);
        done_en = 1'b1;
        idle(2);

        // ---------------- reset mid-read ----------------
        start(1'b0, c_base | 22'd3, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge cpu_clk);
            if (vram_cpu_req) seen = 1'b1;
        end
        check("rr_started", 32'(seen), 1);
        @(negedge cpu_clk);
        reset   = 1'b1;
        bus_req = 1'b0;
        @(negedge cpu_clk);
        check("rr_req_drop", 32'(vram_cpu_req), 0);
        check("rr_busy", 32'(bus_busy), 0);
        check("rr_errcnt", 32'(err_count), 0);
        reset = 1'b0;
        act = 0;
        repeat (8) begin
            @(negedge cpu_clk);
            if (bus_ack) act++;
        end
        check("rr_no_ack", 32'(act), 0);

        start(1'b0, c_base | 22'd2, 32'h0);
        run_to_ack(40, seen, acc, ack, req_cnt, wr_cnt, st_addr, st_data);
        bus_req = 1'b0;
        check("rr_rd_ack_seen", 32'(seen), 1);
        check("rr_rd_data", bus_data_out, 32'hC0DE0002);
        check("rr_rd_latency", 32'(ack - acc), 5);
        check("rr_rd_err", 32'(bus_err), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
